// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants and types for the register-file write-back controller
package rf_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int FIFO_D   = 4;
    localparam int MAX_PEND = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LNG = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering long-latency write-back results
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_D
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;
    wb_entry_t   mem_q [DEPTH];

    // Status flags and pointer advance; the extra MSB distinguishes full from empty
    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
        head     = mem_q[rd_ptr_q[PW-1:0]];
    end

    // Pointer registers; clearing them discards whatever was stored
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: merges ALU and long-latency results onto the RF write port and tracks pending long writes
module rf_wb_ctrl
    import rf_wb_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] q_addrA,
    input  logic [ADDR_W-1:0] q_addrB,
    output logic              q_busyA,
    output logic              q_busyB,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lng_valid,
    output logic              lng_ready,
    input  logic [ADDR_W-1:0] lng_addr,
    input  logic [DATA_W-1:0] lng_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int PCW  = $clog2(MAX_PEND + 1);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [PCW-1:0]    pend_cnt_q, pend_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    wb_src_e           src_q, src_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic [ADDR_W-1:0] lng_addr_q, lng_addr_d;

    logic              iss_set, lng_clr;
    logic              push, pop, full, empty, any_sel;
    logic              alu_err, push_err, hold_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    wb_entry_t         din, head;

    wb_fifo #(.DEPTH(FIFO_D)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Issue acceptance, hazard queries, and scoreboard set/clear strobes
    always_comb begin
        iss_ready = (iss_rd == '0) || (!busy_q[iss_rd] && pend_cnt_q < PCW'(MAX_PEND));
        iss_set   = iss_valid && iss_ready && iss_rd != '0;
        lng_clr   = wr_en_q && src_q == SRC_LNG;
        q_busyA   = busy_q[q_addrA];
        q_busyB   = busy_q[q_addrB];
    end

    // Next scoreboard state; a clear lands on the same edge the RF commits the data
    always_comb begin
        busy_d = busy_q;
        if (lng_clr) busy_d[wr_addr_q] = 1'b0;
        if (iss_set) busy_d[iss_rd] = 1'b1;
        busy_d[0]  = 1'b0;
        pend_cnt_d = pend_cnt_q + PCW'(iss_set) - PCW'(lng_clr);
    end

    // FIFO push/pop and write-port arbitration: ALU always wins the slot
    always_comb begin
        lng_ready = !full;
        push      = lng_valid && !full;
        din       = '{addr: lng_addr, data: lng_data};
        pop       = !alu_valid && !empty;
        any_sel   = alu_valid || !empty;
        sel_addr  = alu_valid ? alu_addr : head.addr;
        sel_data  = alu_valid ? alu_data : head.data;
        wr_en_d   = any_sel && sel_addr != '0;
        wr_addr_d = any_sel ? sel_addr : wr_addr_q;
        wr_data_d = any_sel ? sel_data : wr_data_q;
        src_d     = alu_valid ? SRC_ALU : SRC_LNG;
    end

    // Protocol checks feeding the sticky error flag
    always_comb begin
        alu_err    = alu_valid && busy_q[alu_addr];
        push_err   = push && lng_addr != '0 && !busy_q[lng_addr];
        hold_err   = hold_q && lng_valid && lng_addr != lng_addr_q;
        err_d      = err_q || alu_err || push_err || hold_err;
        hold_d     = lng_valid && full;
        lng_addr_d = lng_addr;
    end

    // Scoreboard and outstanding-op counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Registered write port with its source tag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            src_q     <= SRC_ALU;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            src_q     <= src_d;
        end
    end

    // Error flag and stalled-producer tracking for the hold check
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            lng_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            hold_q     <= hold_d;
            lng_addr_q <= lng_addr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed table and sequence checks for the write-back controller
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  q_addrA, q_addrB;
    logic        q_busyA, q_busyB;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_addr;
    logic [31:0] lng_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] rf [32];

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  qa;
        logic [4:0]  qb;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_ir;
        logic        e_ba;
        logic        e_bb;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_err;
    } vec_t;

    vec_t tv [14];

    rf_wb_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .q_addrA   (q_addrA),
        .q_addrB   (q_addrB),
        .q_busyA   (q_busyA),
        .q_busyB   (q_busyB),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lng_valid (lng_valid),
        .lng_ready (lng_ready),
        .lng_addr  (lng_addr),
        .lng_data  (lng_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Register file model fed by the write port
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = 5'd0; q_addrA = 5'd0; q_addrB = 5'd0;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        lng_valid = 1'b0; lng_addr = 5'd0; lng_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        iss_valid = 1'b1;
        iss_rd = r;
        #1 chk1("issue_ready", iss_ready, 1'b1);
        tick();
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic hog);
        idle();
        alu_valid = hog; alu_addr = 5'd20; alu_data = 32'h5;
        lng_valid = 1'b1; lng_addr = a; lng_data = d;
        #1 chk1("push_ready", lng_ready, 1'b1);
        tick();
    endtask

    initial begin
        tv[0]  = '{0,5'd0,5'd5,5'd0, 0,5'd0,32'h0, 0,5'd0,32'h0,          1,0,0,1, 0,5'd0,32'h0, 0};
        tv[1]  = '{1,5'd5,5'd5,5'd0, 0,5'd0,32'h0, 0,5'd0,32'h0,          1,0,0,1, 0,5'd0,32'h0, 0};
        tv[2]  = '{0,5'd5,5'd5,5'd0, 0,5'd0,32'h0, 1,5'd5,32'hDEAD_BEEF,  0,1,0,1, 0,5'd0,32'h0, 0};
        tv[3]  = '{0,5'd5,5'd5,5'd0, 0,5'd0,32'h0, 0,5'd0,32'h0,          0,1,0,1, 1,5'd5,32'hDEAD_BEEF, 0};
        tv[4]  = '{0,5'd5,5'd5,5'd0, 0,5'd0,32'h0, 0,5'd0,32'h0,          0,1,0,1, 0,5'd0,32'h0, 0};
        tv[5]  = '{0,5'd5,5'd5,5'd0, 0,5'd0,32'h0, 0,5'd0,32'h0,          1,0,0,1, 0,5'd0,32'h0, 0};
        tv[6]  = '{1,5'd8,5'd8,5'd3, 0,5'd0,32'h0, 0,5'd0,32'h0,          1,0,0,1, 0,5'd0,32'h0, 0};
        tv[7]  = '{0,5'd8,5'd8,5'd3, 1,5'd3,32'h11, 1,5'd8,32'h22,        0,1,0,1, 1,5'd3,32'h11, 0};
        tv[8]  = '{0,5'd8,5'd8,5'd3, 1,5'd3,32'h11, 0,5'd0,32'h0,         0,1,0,1, 1,5'd3,32'h11, 0};
        tv[9]  = '{0,5'd8,5'd8,5'd3, 1,5'd3,32'h11, 0,5'd0,32'h0,         0,1,0,1, 1,5'd3,32'h11, 0};
        tv[10] = '{0,5'd8,5'd8,5'd3, 1,5'd3,32'h11, 0,5'd0,32'h0,         0,1,0,1, 1,5'd3,32'h11, 0};
        tv[11] = '{0,5'd8,5'd8,5'd3, 0,5'd0,32'h0, 0,5'd0,32'h0,          0,1,0,1, 1,5'd8,32'h22, 0};
        tv[12] = '{0,5'd8,5'd8,5'd3, 0,5'd0,32'h0, 0,5'd0,32'h0,          0,1,0,1, 0,5'd0,32'h0, 0};
        tv[13] = '{0,5'd8,5'd8,5'd3, 0,5'd0,32'h0, 0,5'd0,32'h0,          1,0,0,1, 0,5'd0,32'h0, 0};

        idle();
        nrst = 1'b0;
        #1;
        chk1("rst_wr_en", wr_en, 1'b0);
        chk32("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk32("rst_wr_data", wr_data, 32'd0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_lng_ready", lng_ready, 1'b1);
        tick();
        tick();
        nrst = 1'b1;

        // RAW on a long op, then ALU contention against a queued long result
        for (int i = 0; i < 14; i++) begin
            iss_valid = tv[i].iv; iss_rd = tv[i].ird; q_addrA = tv[i].qa; q_addrB = tv[i].qb;
            alu_valid = tv[i].av; alu_addr = tv[i].aa; alu_data = tv[i].ad;
            lng_valid = tv[i].lv; lng_addr = tv[i].la; lng_data = tv[i].ld;
            #2;
            chk1($sformatf("v%0d_iss_ready", i), iss_ready, tv[i].e_ir);
            chk1($sformatf("v%0d_busyA", i), q_busyA, tv[i].e_ba);
            chk1($sformatf("v%0d_busyB", i), q_busyB, tv[i].e_bb);
            chk1($sformatf("v%0d_lng_ready", i), lng_ready, tv[i].e_lr);
            tick();
            chk1($sformatf("v%0d_wr_en", i), wr_en, tv[i].e_we);
            if (tv[i].e_we) begin
                chk32($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tv[i].e_wa));
                chk32($sformatf("v%0d_wr_data", i), wr_data, tv[i].e_wd);
            end
            chk1($sformatf("v%0d_err", i), err, tv[i].e_err);
        end
        chk32("rf_r5", rf[5], 32'hDEAD_BEEF);
        chk32("rf_r8", rf[8], 32'h22);
        chk32("rf_r3", rf[3], 32'h11);

        // Pending-op limit
        for (int r = 1; r <= 4; r++) issue(5'(r));
        idle(); iss_rd = 5'd9;
        #1 chk1("pend_full_ready", iss_ready, 1'b0);
        push(5'd2, 32'h2222, 1'b0);
        idle(); iss_rd = 5'd9;
        tick();
        chk1("r2_wr_en", wr_en, 1'b1);
        chk32("r2_wr_addr", 32'(wr_addr), 32'd2);
        chk1("pre_clear_ready", iss_ready, 1'b0);
        tick();
        chk1("post_clear_ready", iss_ready, 1'b1);
        iss_rd = 5'd3;
        #1 chk1("busy_r3_ready", iss_ready, 1'b0);
        iss_rd = 5'd2;
        #1 chk1("freed_r2_ready", iss_ready, 1'b1);
        push(5'd1, 32'h1, 1'b0);
        push(5'd3, 32'h3, 1'b0);
        push(5'd4, 32'h4, 1'b0);
        idle();
        repeat (5) tick();
        q_addrA = 5'd4; q_addrB = 5'd1;
        #1;
        chk1("drain_busyA", q_busyA, 1'b0);
        chk1("drain_busyB", q_busyB, 1'b0);
        chk1("drain_err", err, 1'b0);

        // FIFO fill while ALU hogs, then in-order drain across the pointer wrap
        for (int r = 10; r <= 13; r++) issue(5'(r));
        for (int i = 0; i < 4; i++) push(5'(10 + i), 32'hA0 + 32'(i), 1'b1);
        idle(); alu_valid = 1'b1; alu_addr = 5'd20;
        #1 chk1("full_ready", lng_ready, 1'b0);
        tick();
        idle();
        #1 chk1("pop_cycle_ready", lng_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1($sformatf("drain%0d_wr_en", i), wr_en, 1'b1);
            chk32($sformatf("drain%0d_wr_addr", i), 32'(wr_addr), 32'(10 + i));
            chk32($sformatf("drain%0d_wr_data", i), wr_data, 32'hA0 + 32'(i));
        end
        tick();
        chk1("drained_wr_en", wr_en, 1'b0);
        chk1("drained_ready", lng_ready, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) chk32($sformatf("rf_r%0d", 10 + i), rf[10 + i], 32'hA0 + 32'(i));
        issue(5'd10);
        push(5'd10, 32'hB0, 1'b0);
        idle();
        tick();
        chk32("wrap_wr_addr", 32'(wr_addr), 32'd10);
        chk32("wrap_wr_data", wr_data, 32'hB0);
        tick();
        tick();
        chk1("wrap_err", err, 1'b0);

        // Register 0 handling and the ALU-to-busy error
        idle(); iss_valid = 1'b1; iss_rd = 5'd0;
        #1 chk1("r0_ready", iss_ready, 1'b1);
        tick();
        idle();
        #1 chk1("r0_busy", q_busyA, 1'b0);
        push(5'd0, 32'h77, 1'b0);
        idle();
        tick();
        chk1("r0_pop_wr_en", wr_en, 1'b0);
        tick();
        chk1("r0_after_wr_en", wr_en, 1'b0);
        chk1("r0_err", err, 1'b0);
        issue(5'd4);
        idle(); alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        tick();
        chk1("alu_busy_err", err, 1'b1);
        chk32("alu_busy_wr_addr", 32'(wr_addr), 32'd4);
        idle();
        tick();
        tick();
        chk1("err_sticky", err, 1'b1);

        // Reset in the middle of a burst
        issue(5'd5);
        issue(5'd6);
        issue(5'd7);
        push(5'd5, 32'h55, 1'b1);
        push(5'd6, 32'h66, 1'b1);
        push(5'd7, 32'h77, 1'b1);
        idle(); q_addrA = 5'd5; q_addrB = 5'd6;
        nrst = 1'b0;
        #1;
        chk1("mid_rst_wr_en", wr_en, 1'b0);
        chk1("mid_rst_err", err, 1'b0);
        chk1("mid_rst_ready", lng_ready, 1'b1);
        chk1("mid_rst_busyA", q_busyA, 1'b0);
        chk1("mid_rst_busyB", q_busyB, 1'b0);
        tick();
        nrst = 1'b1;
        tick();
        chk1("post_rst_wr_en", wr_en, 1'b0);
        q_addrA = 5'd7;
        #1 chk1("post_rst_busy7", q_busyA, 1'b0);
        for (int r = 1; r <= 4; r++) issue(5'(r));
        idle(); iss_rd = 5'd9;
        #1 chk1("post_rst_pend_full", iss_ready, 1'b0);

        // Producer changing address while stalled on a full FIFO
        for (int r = 1; r <= 4; r++) push(5'(r), 32'hC0 + 32'(r), 1'b1);
        idle(); alu_valid = 1'b1; alu_addr = 5'd20;
        lng_valid = 1'b1; lng_addr = 5'd1; lng_data = 32'h99;
        #1 chk1("stall_ready", lng_ready, 1'b0);
        tick();
        chk1("stall_err0", err, 1'b0);
        tick();
        chk1("stall_hold_err", err, 1'b0);
        lng_addr = 5'd2;
        tick();
        chk1("stall_change_err", err, 1'b1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
